// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
package mult_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    // The watchdog must be able to hold the value TIMEOUT itself.
    function automatic int wdog_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus: request levels and operands in, grant/done/result back.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a;
    logic [N_REQ*WIDTH-1:0] b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [2*WIDTH-1:0]     result;
    logic                   err;

    modport master (
        output req, a, b,
        input  gnt, done, result, err
    );

    modport slave (
        input  req, a, b,
        output gnt, done, result, err
    );

endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_i+1 upward, wrapping.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = IDX_W'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among N_REQ requesters: round-robin grant,
// start pulse, ready-handshake tracking with a watchdog, and result return.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    mult_arbiter_if.slave      bus,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_v1,
    output logic [WIDTH-1:0]   mul_v2,
    input  logic               mul_ready,
    input  logic [2*WIDTH-1:0] mul_out
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = wdog_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [WIDTH-1:0]   v1_q, v1_d, v2_q, v2_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               err_q, err_d;
    logic               timeout;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.a[g*WIDTH +: WIDTH];
        assign b_arr[g] = bus.b[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        wdog_d   = wdog_q;
        result_d = result_q;
        err_d    = err_q;
        timeout  = (wdog_q == WD_LIMIT);
        unique case (state_q)
            IDLE: begin
                if (arb_any && mul_ready) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    v1_d    = a_arr[arb_idx];
                    v2_d    = b_arr[arb_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                wdog_d = wdog_q + 1'b1;
                if (timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else if (!mul_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wdog_d = wdog_q + 1'b1;
                // A ready rise wins over a watchdog expiry on the same edge.
                if (mul_ready) begin
                    result_d = mul_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                gnt_d   = '0;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
            v1_q     <= '0;
            v2_q     <= '0;
            wdog_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            wdog_q   <= wdog_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign mul_start  = (state_q == ISSUE);
    assign mul_v1     = v1_q;
    assign mul_v2     = v2_q;
    assign bus.gnt    = gnt_q;
    assign bus.done   = (state_q == RESP) ? gnt_q : '0;
    assign bus.result = result_q;
    assign bus.err    = (state_q == RESP) && err_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one sequential 8x8 shift-add multiplier among N_REQ requesters. It sits between the requesters and the multiplier top level and is the only driver of the multiplier's start and operand inputs. It captures operands, pulses start, tracks the multiplier's ready handshake with a watchdog, and returns each 16-bit product to its owner.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; product is 2*WIDTH
- TIMEOUT, 64, max cycles allowed from start pulse to multiplier ready rise
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- req  in  N_REQ  per-requester request level; held with operands stable until that requester's done
- a  in  N_REQ*WIDTH  packed operand A per requester (slice i = requester i)
- b  in  N_REQ*WIDTH  packed operand B per requester
- gnt  out  N_REQ  one-hot; high from grant until done for the owning requester
- done  out  N_REQ  one-hot, one-cycle pulse; result/err valid in that cycle
- result  out  2*WIDTH  shared result bus, valid only while any done bit is high
- err  out  1  high with done when the operation timed out
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_v1, mul_v2  out  WIDTH  registered operands to multiplier, stable from start until the next grant
- mul_ready  in  1  multiplier ready: high when idle/result valid, low while computing
- mul_out  in  2*WIDTH  multiplier product, valid while mul_ready is high after a run

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req is high and mul_ready=1, pick the winner by round robin. The search starts at last_grant+1 and wraps modulo N_REQ. Then register a/b of the winner into mul_v1/mul_v2, set gnt, and go to ISSUE. If mul_ready=0, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; clear watchdog; go to WAIT_BUSY.
- WAIT_BUSY: wait for mul_ready=0, then go to WAIT_DONE.
- WAIT_DONE: wait for mul_ready=1, then capture mul_out into the result register and go to RESP.
- RESP: done[owner]=1, result driven, gnt cleared the cycle after; last_grant <= owner; go to IDLE.
- Watchdog: increments each cycle in WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT, go to RESP with err=1 and result=0.
- A requester that keeps req high after done is re-arbitrated. Round robin guarantees the others are served first.
- req deasserting while granted is ignored: the operation completes and done is still pulsed.
- Simultaneous requests: exactly one grant. A new req arriving in any non-IDLE state waits.

## Timing
- Reset values (rst=0 at a clk edge): state=IDLE, gnt=0, done=0, result=0, err=0, mul_start=0, mul_v1=mul_v2=0, watchdog=0, last_grant=N_REQ-1 (so requester 0 has first priority).
- Reset mid-operation aborts with no done pulse. After reset, mul_ready is trusted only in IDLE.
- Latency: req sampled at edge t → gnt and operands at t+1 → mul_start high during cycle t+1 (ISSUE).
- mul_ready rise seen at edge r → done/result high during cycle r+1, for one cycle.
- Minimum turnaround: done cycle to next mul_start is 2 cycles (IDLE, ISSUE).
- Watchdog boundary: err is asserted when the count equals TIMEOUT. A ready rise on that same edge takes priority, giving a normal completion with err=0.

## Structure
- Package mult_arb_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP), default WIDTH/N_REQ/TIMEOUT constants, watchdog width $clog2(TIMEOUT+1).
- Sub-module rr_arbiter: combinational round-robin picker. Inputs are req and last_grant; outputs are one-hot grant, index, and any.
- Top holds the FSM, operand/result registers and the watchdog.

## Test plan
- Single request: req[2]=1, a=8'd13, b=8'd11, behavioural multiplier (8-cycle busy) → one mul_start pulse, gnt=4'b0100, done[2] pulse with result=16'd143, err=0.
- Contention: req=4'b1111 held continuously from reset → grant order 0,1,2,3,0. Each done carries its own product (e.g., 255*255=16'hFE01 on requester 3).
- Fairness after wrap: last_grant=3, req=4'b1001 → requester 0 served before 3.
- Timeout: multiplier model never raises mul_ready after start, TIMEOUT=64 → done pulse 65 cycles after WAIT_BUSY entry, err=1, result=0, then the next request is served.
- Reset mid-run: rst=0 during WAIT_DONE → all outputs 0 on the next edge, no done. After release, req[1] is served with the correct product.
- Boundary operands: 0*200 → result 0; 1*255 → 16'd255; req dropped while granted → done still pulsed.
